// File: rtl/interleaver_stage_1_if.sv
// Request/response bundle between the QPP interleaver front stage and its driver.
// Carries param_err only when INTLV_S1_PARAM_CHECK_EN is defined.
interface interleaver_stage_1_if #(
    parameter int KW = 13,
    parameter int CW = 10
);
    logic          start;
    logic [KW-1:0] K_i;
    logic [8:0]    f1_i;
    logic [9:0]    f2_i;
    logic [KW-3:0] Theta_1_0;
    logic [KW+1:0] Theta_0;
    logic [KW+1:0] Theta_1;
    logic [KW-1:0] Pi2n_plus_K4_init;
    logic [KW-1:0] Pi2n_plus_K2_init;
    logic [KW-1:0] Pi2n_plus_3K4_init;
    logic [CW-1:0] counter_r;
    logic          busy;
    logic          run_valid;
    logic          done;
`ifdef INTLV_S1_PARAM_CHECK_EN
    logic          param_err;
`endif

    modport master (
        output start, K_i, f1_i, f2_i,
        input  Theta_1_0, Theta_0, Theta_1,
        input  Pi2n_plus_K4_init, Pi2n_plus_K2_init, Pi2n_plus_3K4_init,
        input  counter_r, busy, run_valid, done
`ifdef INTLV_S1_PARAM_CHECK_EN
        , input param_err
`endif
    );

    modport slave (
        input  start, K_i, f1_i, f2_i,
        output Theta_1_0, Theta_0, Theta_1,
        output Pi2n_plus_K4_init, Pi2n_plus_K2_init, Pi2n_plus_3K4_init,
        output counter_r, busy, run_valid, done
`ifdef INTLV_S1_PARAM_CHECK_EN
        , output param_err
`endif
    );
endinterface

// File: rtl/interleaver_stage_1.sv
// QPP interleaver front stage: seeds, quarter-block addresses and per-step Theta increments.
// Optional INTLV_S1_PARAM_CHECK_EN rejects illegal K/f1/f2 at start and pulses param_err.
module interleaver_stage_1 #(
    parameter int KW = 13,
    parameter int CW = 10
) (
    input logic                  clk,
    input logic                  dff_clr,
    interleaver_stage_1_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRE, MUL, RUN, DONE} state_t;
    localparam logic [3:0] LAST_BIT = 4'(KW - 1);

    state_t        state, state_nxt;
    logic [KW-1:0] k_r, f1_r, f2_r, q_r, m_r, mul_sh, acc_r, t_r;
    logic [KW-1:0] d1_r, d_r, t0_r, t1_r;
    logic [KW-1:0] theta0_r, theta1_r, pi_k4_r, pi_k2_r, pi_3k4_r;
    logic [KW-3:0] theta10_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    ph_r;
    logic [3:0]    bit_r;
    logic [2:0]    prod_r;
    logic          start_ok, mul_end, run_last, busy, run_valid, done;
    logic [KW-1:0] dbl, mcand, mul_nxt, pi1;

    function automatic logic [KW-1:0] addmod(input logic [KW-1:0] a, input logic [KW-1:0] b,
                                             input logic [KW-1:0] m);
        logic [KW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[KW-1:0];
    endfunction

    // One double-and-add step; even products multiply by f2, odd ones by t
    always_comb begin
        dbl     = addmod(acc_r, acc_r, k_r);
        mcand   = prod_r[0] ? t_r : f2_r;
        mul_nxt = mul_sh[KW-1] ? addmod(dbl, mcand, k_r) : dbl;
        pi1     = addmod(f1_r, f2_r, k_r);
    end

    assign mul_end  = (bit_r == LAST_BIT);
    assign run_last = (cnt_r == (CW'(k_r >> 3) - CW'(1)));

`ifdef INTLV_S1_PARAM_CHECK_EN
    logic param_bad, param_err_r;
    assign param_bad = (bus.K_i < KW'(40)) || (bus.K_i > KW'(6144)) || (bus.K_i[2:0] != 3'd0) ||
                       !bus.f1_i[0] || bus.f2_i[0] ||
                       (KW'(bus.f1_i) >= bus.K_i) || (KW'(bus.f2_i) >= bus.K_i);
    assign start_ok  = bus.start && !param_bad;
    always_ff @(posedge clk or posedge dff_clr) begin
        if (dff_clr) param_err_r <= 1'b0;
        else         param_err_r <= (state == IDLE) && bus.start && param_bad;
    end
    assign bus.param_err = param_err_r;
`else
    assign start_ok = bus.start;
`endif

    always_ff @(posedge clk or posedge dff_clr) begin
        if (dff_clr) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        run_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start_ok) state_nxt = PRE;
            PRE: begin
                busy = 1'b1;
                if (ph_r == 2'd3) state_nxt = MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (mul_end && prod_r == 3'd5) state_nxt = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                run_valid = 1'b1;
                if (run_last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge dff_clr) begin
        if (dff_clr) begin
            k_r <= '0; f1_r <= '0; f2_r <= '0; q_r <= '0; m_r <= '0; mul_sh <= '0;
            acc_r <= '0; t_r <= '0; d1_r <= '0; d_r <= '0; t0_r <= '0; t1_r <= '0;
            theta0_r <= '0; theta1_r <= '0; theta10_r <= '0;
            pi_k4_r <= '0; pi_k2_r <= '0; pi_3k4_r <= '0;
            cnt_r <= '0; ph_r <= '0; bit_r <= '0; prod_r <= '0;
        end else begin
            case (state)
                IDLE: if (start_ok) begin
                    k_r  <= bus.K_i;
                    f1_r <= KW'(bus.f1_i);
                    f2_r <= KW'(bus.f2_i);
                    ph_r <= '0;
                end
                PRE: begin
                    // d_r walks 2f2 -> 4f2 -> 8f2 (= D) across the phases
                    ph_r <= ph_r + 2'd1;
                    case (ph_r)
                        2'd0: begin
                            q_r       <= k_r >> 2;
                            theta10_r <= pi1[KW-3:0];
                            d1_r      <= addmod(f1_r, f1_r, k_r);
                            d_r       <= addmod(f2_r, f2_r, k_r);
                        end
                        2'd1: d_r <= addmod(d_r, d_r, k_r);
                        2'd2: begin
                            t0_r <= addmod(d1_r, d_r, k_r);
                            d_r  <= addmod(d_r, d_r, k_r);
                        end
                        default: begin
                            t1_r   <= addmod(d1_r, d_r, k_r);
                            m_r    <= q_r;
                            mul_sh <= q_r;
                            acc_r  <= '0;
                            bit_r  <= '0;
                            prod_r <= '0;
                        end
                    endcase
                end
                MUL: begin
                    acc_r  <= mul_end ? '0 : mul_nxt;
                    bit_r  <= mul_end ? '0 : bit_r + 4'd1;
                    mul_sh <= mul_sh << 1;
                    if (mul_end) begin
                        prod_r <= prod_r + 3'd1;
                        if (!prod_r[0]) begin
                            t_r    <= addmod(mul_nxt, f1_r, k_r);
                            mul_sh <= m_r;
                        end else begin
                            case (prod_r[2:1])
                                2'd0:    pi_k4_r  <= mul_nxt;
                                2'd1:    pi_k2_r  <= mul_nxt;
                                default: pi_3k4_r <= mul_nxt;
                            endcase
                            m_r    <= m_r + q_r;
                            mul_sh <= m_r + q_r;
                            if (prod_r == 3'd5) begin
                                theta0_r <= t0_r;
                                theta1_r <= t1_r;
                                cnt_r    <= '0;
                            end
                        end
                    end
                end
                RUN: begin
                    if (run_last) cnt_r <= '0;
                    else begin
                        cnt_r <= cnt_r + CW'(1);
                        // steps 0 and 1 share the seed; D accumulates from step 2
                        if (cnt_r != '0) begin
                            theta0_r <= addmod(theta0_r, d_r, k_r);
                            theta1_r <= addmod(theta1_r, d_r, k_r);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Theta_1_0          = theta10_r;
    assign bus.Theta_0            = {2'b00, theta0_r};
    assign bus.Theta_1            = {2'b00, theta1_r};
    assign bus.Pi2n_plus_K4_init  = pi_k4_r;
    assign bus.Pi2n_plus_K2_init  = pi_k2_r;
    assign bus.Pi2n_plus_3K4_init = pi_3k4_r;
    assign bus.counter_r          = cnt_r;
    assign bus.busy               = busy;
    assign bus.run_valid          = run_valid;
    assign bus.done               = done;
endmodule

// File: doc/interleaver_stage_1.md
Name: interleaver_stage_1

Overview:
- Front stage of the two-stage QPP turbo interleaver address generator, where Pi(i) = (f1*i + f2*i^2) mod K.
- On start, it computes the recursion seeds and the three quarter-block initial addresses using a sequential modular multiplier.
- It then runs a step counter and emits per-step increments, Theta_0 for even lanes and Theta_1 for odd lanes.
- These feed the downstream stage_2, which produces 8 addresses per cycle.

Parameters:
- KW, 13: width of K and of all address outputs.
- CW, 10: width of counter_r; the maximum step count is K/8 = 768.

Ports:
- clk  in  1  single clock, rising edge.
- dff_clr  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a new block; sampled only in IDLE.
- K_i  in  13  block size; legal values 40..6144, multiple of 8; must be held stable while busy.
- f1_i  in  9  QPP coefficient f1, f1 < K.
- f2_i  in  10  QPP coefficient f2, f2 < K.
- Theta_1_0  out  11  Pi(1) = (f1+f2) mod K.
- Theta_0  out  15  even-lane increment, zero-extended, value < K.
- Theta_1  out  15  odd-lane increment, zero-extended, value < K.
- Pi2n_plus_K4_init  out  13  Pi(K/4).
- Pi2n_plus_K2_init  out  13  Pi(K/2).
- Pi2n_plus_3K4_init  out  13  Pi(3K/4).
- counter_r  out  10  step index n.
- busy  out  1  high from the cycle after start until return to IDLE.
- run_valid  out  1  high while in RUN; stage_2 outputs are meaningful only on these cycles.
- done  out  1  one-cycle pulse after the last step.

Behaviour:
- Reset (async): state = IDLE; all outputs and internal registers are 0.
- FSM states: IDLE -> PRE -> MUL -> RUN -> DONE -> IDLE.
- IDLE: start = 1 latches K, f1, f2 and moves to PRE. Start is ignored in every other state.
- PRE (4 cycles) computes:
  - q = K>>2
  - Theta_1_0 = (f1+f2) mod K
  - T0 = (2f1 + 4f2) mod K
  - T1 = (2f1 + 8f2) mod K
  - D = 8f2 mod K
  - Each doubling and addition reduces with a single conditional subtract of K.
- MUL (6 products, 13 cycles each, 78 cycles total):
  - Multiplier: MSB-first double-and-add over the 13 multiplier bits. acc = 2acc mod K, then if the bit is set, acc = (acc + a) mod K. Each step uses one conditional subtract; no divider.
  - Order of products: t = (f2*q mod K + f1) mod K, then Pi(K/4) = q*t mod K. Repeat for m = 2q and m = 3q.
  - Each init output register updates when its product completes.
- Setup latency: exactly 82 cycles (PRE + MUL). RUN is entered on cycle 83 after start.
- RUN lasts K/8 cycles, with counter_r = 0, 1, ..., K/8-1, incrementing by 1 each cycle.
  - At counter_r = 0 and 1: Theta_0 = T0 and Theta_1 = T1.
  - At counter_r = n >= 2: Theta_0 = (T0 + (n-1)D) mod K and Theta_1 = (T1 + (n-1)D) mod K, each updated by one modular add per cycle.
  - Values are registered; the downstream stage adds them combinationally in the same cycle as counter_r.
- DONE (1 cycle): done = 1, counter_r = 0, run_valid = 0. The next cycle is IDLE with busy = 0.
  - Theta and init outputs hold their last values until the next start.
- Wrap-around: counter_r never exceeds K/8-1.
  - For K = 40, RUN lasts exactly 5 cycles.
  - For K = 6144, RUN lasts exactly 768 cycles, ending at counter_r = 767.
- Reset mid-operation (any state): immediate return to IDLE with all outputs 0. No partial done pulse.
- start asserted in the same cycle as DONE: ignored. A new start is required once the block is in IDLE.

Optional Feature:
- Macro: INTLV_S1_PARAM_CHECK_EN.
- When defined:
  - Adds output param_err (1 bit).
  - In IDLE, start with any of the following is rejected: K < 40, K > 6144, K mod 8 != 0, f1 even, f2 odd, f1 >= K, f2 >= K.
  - On rejection: the block stays in IDLE, busy stays 0, and param_err pulses for 1 cycle.
- When undefined: no param_err port; the block starts unconditionally and out-of-range parameters give undefined addresses.

Test Plan:
- K=40, f1=3, f2=10, start -> after 82 cycles the following hold, with 5 RUN cycles and done on the 6th:
  - Theta_1_0 = 13
  - Pi2n_plus_K4_init = 30
  - Pi2n_plus_K2_init = 20
  - Pi2n_plus_3K4_init = 10
  - Theta_0 = 6 and Theta_1 = 6 on every RUN cycle, since D = 0
- K=6144, f1=263, f2=480 -> the following hold, with counter_r running 0..767 and done once:
  - Theta_1_0 = 743
  - Pi2n_plus_K4_init = 4608
  - Pi2n_plus_K2_init = 3072
  - Pi2n_plus_3K4_init = 1536
  - Theta_0 = 2446 at n = 1 and (2446+3840) mod 6144 = 142 at n = 2
  - Theta_1 = 4366 at n = 1
- Chain with stage_2 for K=6144 and several other legal K values -> every 8-lane address equals the direct (f1*i + f2*i^2) mod K reference, and the K addresses form a permutation.
- Assert dff_clr at counter_r = 100 in RUN -> next cycle all outputs are 0 and state is IDLE; a fresh start then reproduces the full sequence.
- Pulse start during MUL and again during RUN -> ignored; latency and values are unchanged.
- With INTLV_S1_PARAM_CHECK_EN defined: start with K=44 -> param_err pulses once, busy stays 0. Start with K=40, f1=2 -> rejected.
